dircc_processing_mem_msg_dma: RTL

Message DMA sequencer owning port 2 (16-bit side) of a node's dual-port processing memory. It streams outgoing messages out of memory onto a valid/ready stream and writes incoming stream words into an armed receive buffer. The transmit and receive channels share the single memory port through a round-robin arbiter. Port 1 (32-bit side) stays with the node processor; this block is the only master on port 2.

---
 rtl/dircc_processing_mem_msg_dma.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/dircc_processing_mem_msg_dma.sv
// Message DMA for port 2 of the node processing memory: a TX channel that streams
// memory words out and an RX channel that commits stream words into memory.
module dircc_processing_mem_msg_dma #(
    parameter int ADDR_W = 15,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tx_start,
    input  logic [ADDR_W-1:0] tx_base,
    input  logic [LEN_W-1:0]  tx_len,
    output logic              tx_busy,
    output logic              tx_done,
    output logic [15:0]       tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic              rx_arm,
    input  logic [ADDR_W-1:0] rx_base,
    input  logic [LEN_W-1:0]  rx_len,
    input  logic [15:0]       rx_data,
    input  logic              rx_last,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              rx_busy,
    output logic              rx_done,
    output logic [LEN_W-1:0]  rx_count,
    output logic              rx_overflow,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [15:0]       mem_writedata,
    output logic [1:0]        mem_byteenable,
    output logic              mem_clken,
    input  logic [15:0]       mem_readdata
);
    typedef enum logic [2:0] {
        TX_IDLE, TX_ISSUE, TX_CAPTURE, TX_PRESENT, TX_DONE
    } tx_state_t;

    tx_state_t         r_tx_state;
    logic [ADDR_W-1:0] r_tx_base;
    logic [LEN_W-1:0]  r_tx_len;
    logic [LEN_W-1:0]  r_tx_off;
    logic              r_tx_busy;
    logic              r_tx_done;
    logic [15:0]       r_tx_data;
    logic              r_tx_valid;

    logic [ADDR_W-1:0] r_rx_base;
    logic [LEN_W-1:0]  r_rx_len;
    logic [LEN_W-1:0]  r_rx_count;
    logic              r_rx_busy;
    logic              r_rx_done;
    logic              r_rx_overflow;
    logic              r_buf_full;
    logic [15:0]       r_buf_data;
    logic              r_buf_last;

    logic              r_prio_tx;

    logic              w_tx_req;
    logic              w_rx_req;
    logic              w_grant_tx;
    logic              w_grant_rx;
    logic              w_rx_hs;
    logic [LEN_W-1:0]  w_tx_off_inc;

    assign w_tx_req     = (r_tx_state == TX_ISSUE) && (r_tx_len != '0);
    assign w_rx_req     = r_buf_full;
    // Round-robin: on contention the channel not served last time wins.
    assign w_grant_tx   = w_tx_req && (!w_rx_req || r_prio_tx);
    assign w_grant_rx   = w_rx_req && (!w_tx_req || !r_prio_tx);
    assign w_rx_hs      = rx_valid && rx_ready;
    assign w_tx_off_inc = r_tx_off + LEN_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prio_tx <= 1'b0;
        end else if (w_grant_tx) begin
            r_prio_tx <= 1'b0;
        end else if (w_grant_rx) begin
            r_prio_tx <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_state <= TX_IDLE;
            r_tx_base  <= '0;
            r_tx_len   <= '0;
            r_tx_off   <= '0;
            r_tx_busy  <= 1'b0;
            r_tx_done  <= 1'b0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
        end else begin
            r_tx_done <= 1'b0;
            case (r_tx_state)
                TX_IDLE: begin
                    if (tx_start) begin
                        r_tx_base  <= tx_base;
                        r_tx_len   <= tx_len;
                        r_tx_off   <= '0;
                        r_tx_busy  <= 1'b1;
                        r_tx_state <= TX_ISSUE;
                    end
                end
                TX_ISSUE: begin
                    // Empty message finishes here without ever requesting the port.
                    if (r_tx_len == '0) begin
                        r_tx_busy  <= 1'b0;
                        r_tx_done  <= 1'b1;
                        r_tx_state <= TX_DONE;
                    end else if (w_grant_tx) begin
                        r_tx_state <= TX_CAPTURE;
                    end
                end
                TX_CAPTURE: begin
                    r_tx_data  <= mem_readdata;
                    r_tx_valid <= 1'b1;
                    r_tx_state <= TX_PRESENT;
                end
                TX_PRESENT: begin
                    if (tx_ready) begin
                        r_tx_valid <= 1'b0;
                        r_tx_off   <= w_tx_off_inc;
                        if (w_tx_off_inc < r_tx_len) begin
                            r_tx_state <= TX_ISSUE;
                        end else begin
                            r_tx_busy  <= 1'b0;
                            r_tx_done  <= 1'b1;
                            r_tx_state <= TX_DONE;
                        end
                    end
                end
                default: r_tx_state <= TX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_base     <= '0;
            r_rx_len      <= '0;
            r_rx_count    <= '0;
            r_rx_busy     <= 1'b0;
            r_rx_done     <= 1'b0;
            r_rx_overflow <= 1'b0;
            r_buf_full    <= 1'b0;
            r_buf_data    <= '0;
            r_buf_last    <= 1'b0;
        end else begin
            r_rx_done <= 1'b0;
            if (!r_rx_busy) begin
                if (rx_arm) begin
                    r_rx_base     <= rx_base;
                    r_rx_len      <= rx_len;
                    r_rx_count    <= '0;
                    r_rx_overflow <= 1'b0;
                    r_rx_busy     <= 1'b1;
                end
            end else begin
                if (w_grant_rx) begin
                    r_buf_full <= 1'b0;
                    r_rx_count <= r_rx_count + LEN_W'(1);
                    if (r_buf_last) begin
                        r_rx_busy <= 1'b0;
                        r_rx_done <= 1'b1;
                    end
                end
                // Handshake only happens with an empty buffer, so r_rx_count is current.
                if (w_rx_hs) begin
                    if (r_rx_count == r_rx_len) begin
                        r_rx_overflow <= 1'b1;
                        if (rx_last) begin
                            r_rx_busy <= 1'b0;
                            r_rx_done <= 1'b1;
                        end
                    end else begin
                        r_buf_full <= 1'b1;
                        r_buf_data <= rx_data;
                        r_buf_last <= rx_last;
                    end
                end
            end
        end
    end

    assign tx_busy        = r_tx_busy;
    assign tx_done        = r_tx_done;
    assign tx_data        = r_tx_data;
    assign tx_valid       = r_tx_valid;
    assign rx_ready       = r_rx_busy && !r_buf_full;
    assign rx_busy        = r_rx_busy;
    assign rx_done        = r_rx_done;
    assign rx_count       = r_rx_count;
    assign rx_overflow    = r_rx_overflow;
    assign mem_chipselect = w_grant_tx || w_grant_rx;
    assign mem_write      = w_grant_rx;
    assign mem_address    = w_grant_tx ? (r_tx_base + ADDR_W'(r_tx_off)) :
                            w_grant_rx ? (r_rx_base + ADDR_W'(r_rx_count)) : '0;
    assign mem_writedata  = w_grant_rx ? r_buf_data : '0;
    assign mem_byteenable = 2'b11;
    assign mem_clken      = 1'b1;
endmodule
